mem_stage: RTL



---
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: MIPS32 loads/stores on a request/ack data bus.
// Optional misaligned-access trap: define MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        stallreq,
    output logic        dbus_ce,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        addr_err
);
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_rdata;
    logic        w_load, w_store, w_byte, w_half, w_word, w_sext;
    logic        w_err, w_go, w_ce, w_stall, w_cap;
    logic [1:0]  w_a;
    logic [7:0]  w_bval;
    logic [15:0] w_hval;
    logic [31:0] w_ld;
    logic [3:0]  w_sel;
    logic [31:0] w_bwdata;

    assign w_a = ex_mem_addr[1:0];

    always_comb begin
        w_load  = 1'b0;
        w_store = 1'b0;
        w_byte  = 1'b0;
        w_half  = 1'b0;
        w_word  = 1'b0;
        w_sext  = 1'b0;
        case (ex_aluop)
            EXE_LB_OP:  begin w_load = 1'b1; w_byte = 1'b1; w_sext = 1'b1; end
            EXE_LBU_OP: begin w_load = 1'b1; w_byte = 1'b1; end
            EXE_LH_OP:  begin w_load = 1'b1; w_half = 1'b1; w_sext = 1'b1; end
            EXE_LHU_OP: begin w_load = 1'b1; w_half = 1'b1; end
            EXE_LW_OP:  begin w_load = 1'b1; w_word = 1'b1; end
            EXE_SB_OP:  begin w_store = 1'b1; w_byte = 1'b1; end
            EXE_SH_OP:  begin w_store = 1'b1; w_half = 1'b1; end
            EXE_SW_OP:  begin w_store = 1'b1; w_word = 1'b1; end
            default:    ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign w_err = (w_half & w_a[0]) | (w_word & (w_a != 2'b00));
`else
    assign w_err = 1'b0;
`endif

    assign w_go = (w_load | w_store) & ~w_err;

    always_comb begin
        w_next  = r_state;
        w_ce    = 1'b0;
        w_stall = 1'b0;
        w_cap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_ce    = 1'b1;
                    w_stall = 1'b1;
                    w_cap   = dbus_ack;
                    w_next  = dbus_ack ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                w_ce    = 1'b1;
                w_stall = 1'b1;
                if (dbus_ack) begin
                    w_cap  = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_cap) r_rdata <= dbus_rdata;
        end
    end

    // Big-endian lanes: offset 0 is the most significant byte
    always_comb begin
        w_bval = r_rdata[7:0];
        case (w_a)
            2'd0:    w_bval = r_rdata[31:24];
            2'd1:    w_bval = r_rdata[23:16];
            2'd2:    w_bval = r_rdata[15:8];
            default: w_bval = r_rdata[7:0];
        endcase
        w_hval = w_a[1] ? r_rdata[15:0] : r_rdata[31:16];
        if (w_byte)
            w_ld = {{24{w_sext & w_bval[7]}}, w_bval};
        else if (w_half)
            w_ld = {{16{w_sext & w_hval[15]}}, w_hval};
        else
            w_ld = r_rdata;
    end

    always_comb begin
        if (w_byte) begin
            w_sel    = 4'b1000 >> w_a;
            w_bwdata = {4{ex_reg2[7:0]}};
        end else if (w_half) begin
            w_sel    = w_a[1] ? 4'b0011 : 4'b1100;
            w_bwdata = {2{ex_reg2[15:0]}};
        end else begin
            w_sel    = 4'b1111;
            w_bwdata = ex_reg2;
        end
    end

    always_comb begin
        mem_wd     = 5'd0;
        mem_wreg   = 1'b0;
        mem_wdata  = 32'd0;
        mem_hi     = 32'd0;
        mem_lo     = 32'd0;
        mem_whilo  = 1'b0;
        stallreq   = 1'b0;
        dbus_ce    = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = 32'd0;
        dbus_sel   = 4'd0;
        dbus_wdata = 32'd0;
        addr_err   = 1'b0;
        if (!rst) begin
            mem_wd    = ex_wd;
            mem_wreg  = ex_wreg & ~w_err;
            mem_wdata = w_load ? w_ld : ex_wdata;
            mem_hi    = ex_hi;
            mem_lo    = ex_lo;
            mem_whilo = ex_whilo & ~w_err;
            stallreq  = w_stall;
            dbus_ce   = w_ce;
            addr_err  = w_err;
            if (w_ce) begin
                dbus_we    = w_store;
                dbus_addr  = {ex_mem_addr[31:2], 2'b00};
                dbus_sel   = w_sel;
                dbus_wdata = w_bwdata;
            end
        end
    end
endmodule
